// File: rtl/cpu_pipeline.sv
// cpu_pipeline: five-stage MIPS-subset CPU with instruction ROM, data RAM and board MMIO
// Ports: clk; reset_b (asynchronous, active-high); switch[7:0] readable at 0x40000004;
// led[7:0] at 0x40000000; bcd1..bcd4 active-low {g,f,e,d,c,b,a} hex digits of the
// 16-bit value at 0x40000008 (bcd1 = most significant nibble); uart_rxd/uart_txd 8N1 serial.
// The UART is built only when UART_EN is defined; otherwise uart_txd is 1 and its registers read 0.
// imem is loaded externally with the program image named by IMEM_FILE.
module cpu_pipeline #(
  parameter int IMEM_DEPTH = 256,
  parameter string IMEM_FILE = "imem.hex",
  parameter int DMEM_DEPTH = 256,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic [7:0] switch,
  output logic [7:0] led,
  output logic [6:0] bcd1,
  output logic [6:0] bcd2,
  output logic [6:0] bcd3,
  output logic [6:0] bcd4,
  input  logic       uart_rxd,
  output logic       uart_txd
);
  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);
  localparam logic [15:0][6:0] GLYPH = {7'h0e, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [31:0] imem [0:IMEM_DEPTH-1];
  logic [31:0] dmem [0:DMEM_DEPTH-1];
  logic [31:0] rf [0:31];
  logic [31:0] pc, id_ir, id_pc4, ex_ir, ex_pc4, ex_a, ex_b, mem_res, mem_b, wb_val;
  logic [31:0] a, fb, sx, zx, res, tgt, rdata;
  logic [4:0] id_rs, id_rt, rs, rt, rd, dst, mem_rd, wb_rd;
  logic [5:0] op, fn;
  logic mem_we, mem_ld, mem_st, wb_we, we, wr, ld, st, take, stall;
  logic [15:0] seg;
  logic tx_busy, rx_valid;
  logic [7:0] rx_data;
  logic unused_cfg;
  assign unused_cfg = IMEM_FILE != "";
  // WB writes land in the first half-cycle, so ID sees the value being written this cycle
  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    return (wb_we && wb_rd == r) ? wb_val : rf[r];
  endfunction
  assign id_rs = id_ir[25:21];
  assign id_rt = id_ir[20:16];
  assign op = ex_ir[31:26];
  assign fn = ex_ir[5:0];
  assign rs = ex_ir[25:21];
  assign rt = ex_ir[20:16];
  assign rd = ex_ir[15:11];
  assign sx = {{16{ex_ir[15]}}, ex_ir[15:0]};
  assign zx = {16'd0, ex_ir[15:0]};
  assign a = (mem_we && mem_rd == rs) ? mem_res : (wb_we && wb_rd == rs) ? wb_val : ex_a;
  assign fb = (mem_we && mem_rd == rt) ? mem_res : (wb_we && wb_rd == rt) ? wb_val : ex_b;
  assign ld = op == 6'h23;
  assign st = op == 6'h2b;
  assign dst = op == 6'h00 ? rd : op == 6'h03 ? 5'd31 : rt;
  assign wr = we && !st && dst != 5'd0;
  assign take = (op == 6'h04 && a == fb) || (op == 6'h05 && a != fb) || op == 6'h02 || op == 6'h03 ||
                (op == 6'h00 && fn == 6'h08);
  assign tgt = (op == 6'h04 || op == 6'h05) ? ex_pc4 + {sx[29:0], 2'b00} :
               op == 6'h00 ? a : {ex_pc4[31:28], ex_ir[25:0], 2'b00};
  // a load in EX whose target is read by the instruction in ID costs one bubble
  assign stall = ld && rt != 5'd0 && (rt == id_rs || rt == id_rt);
  always_comb begin
    res = 32'd0;
    we = 1'b1;
    case (op)
      6'h00: case (fn)
        6'h20: res = a + fb;
        6'h22: res = a - fb;
        6'h24: res = a & fb;
        6'h25: res = a | fb;
        6'h2a: res = {31'd0, $signed(a) < $signed(fb)};
        6'h00: res = fb << ex_ir[10:6];
        6'h02: res = fb >> ex_ir[10:6];
        default: we = 1'b0;
      endcase
      6'h08, 6'h23, 6'h2b: res = a + sx;
      6'h0c: res = a & zx;
      6'h0d: res = a | zx;
      6'h0a: res = {31'd0, $signed(a) < $signed(sx)};
      6'h0f: res = {ex_ir[15:0], 16'd0};
      6'h03: res = ex_pc4;
      default: we = 1'b0;
    endcase
  end
  assign rdata = mem_res < 32'h4000_0000 ? dmem[mem_res[DA+1:2]] :
                 mem_res == 32'h4000_0000 ? {24'd0, led} :
                 mem_res == 32'h4000_0004 ? {24'd0, switch} :
                 mem_res == 32'h4000_0008 ? {16'd0, seg} :
                 mem_res == 32'h4000_0010 ? {24'd0, rx_data} :
                 mem_res == 32'h4000_0014 ? {30'd0, rx_valid, tx_busy} : 32'd0;
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      pc <= 32'd0;
      id_ir <= 32'd0;
      id_pc4 <= 32'd0;
      ex_ir <= 32'd0;
      ex_pc4 <= 32'd0;
      ex_a <= 32'd0;
      ex_b <= 32'd0;
      mem_res <= 32'd0;
      mem_b <= 32'd0;
      mem_rd <= 5'd0;
      mem_we <= 1'b0;
      mem_ld <= 1'b0;
      mem_st <= 1'b0;
      wb_val <= 32'd0;
      wb_rd <= 5'd0;
      wb_we <= 1'b0;
      led <= 8'd0;
      seg <= 16'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      pc <= take ? tgt : stall ? pc : pc + 32'd4;
      id_ir <= take ? 32'd0 : stall ? id_ir : imem[pc[IA+1:2]];
      id_pc4 <= stall ? id_pc4 : pc + 32'd4;
      ex_ir <= (take || stall) ? 32'd0 : id_ir;
      ex_pc4 <= id_pc4;
      ex_a <= rd_reg(id_rs);
      ex_b <= rd_reg(id_rt);
      mem_res <= res;
      mem_b <= fb;
      mem_rd <= dst;
      mem_we <= wr;
      mem_ld <= ld;
      mem_st <= st;
      wb_val <= mem_ld ? rdata : mem_res;
      wb_rd <= mem_rd;
      wb_we <= mem_we;
      if (wb_we) rf[wb_rd] <= wb_val;
      if (mem_st && mem_res == 32'h4000_0000) led <= mem_b[7:0];
      if (mem_st && mem_res == 32'h4000_0008) seg <= mem_b[15:0];
    end
  end
  always_ff @(posedge clk) begin
    if (mem_st && mem_res < 32'h4000_0000) dmem[mem_res[DA+1:2]] <= mem_b;
  end
  assign bcd1 = GLYPH[seg[15:12]];
  assign bcd2 = GLYPH[seg[11:8]];
  assign bcd3 = GLYPH[seg[7:4]];
  assign bcd4 = GLYPH[seg[3:0]];
`ifdef UART_EN
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [3:0] tx_n, rx_n;
  logic [9:0] tx_sh;
  logic [7:0] rx_sh;
  logic [2:0] rx_sync;
  logic rx_on, tx_go, rx_rd;
  assign tx_go = mem_st && mem_res == 32'h4000_000c && !tx_busy;
  assign rx_rd = mem_ld && mem_res == 32'h4000_0010;
  assign uart_txd = tx_busy ? tx_sh[0] : 1'b1;
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      tx_busy <= 1'b0;
      tx_cnt <= '0;
      tx_n <= 4'd0;
      tx_sh <= '1;
      rx_sync <= '1;
      rx_on <= 1'b0;
      rx_cnt <= '0;
      rx_n <= 4'd0;
      rx_sh <= 8'd0;
      rx_data <= 8'd0;
      rx_valid <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[1:0], uart_rxd};
      if (tx_go) begin
        tx_busy <= 1'b1;
        tx_sh <= {1'b1, mem_b[7:0], 1'b0};
        tx_cnt <= '0;
        tx_n <= 4'd0;
      end else if (tx_busy) begin
        tx_cnt <= tx_cnt == LAST ? '0 : tx_cnt + 1'b1;
        if (tx_cnt == LAST) begin
          tx_sh <= {1'b1, tx_sh[9:1]};
          tx_n <= tx_n + 4'd1;
          tx_busy <= tx_n != 4'd9;
        end
      end
      if (rx_rd) rx_valid <= 1'b0;
      // starting the count at half a bit puts every sample at mid-bit
      if (!rx_on) begin
        if (rx_sync[2] && !rx_sync[1]) begin
          rx_on <= 1'b1;
          rx_cnt <= CW'(CLKS_PER_BIT / 2);
          rx_n <= 4'd0;
        end
      end else begin
        rx_cnt <= rx_cnt == LAST ? '0 : rx_cnt + 1'b1;
        if (rx_cnt == LAST) begin
          rx_n <= rx_n + 4'd1;
          if (rx_n == 4'd0 && rx_sync[1]) rx_on <= 1'b0;
          if (rx_n != 4'd0 && rx_n != 4'd9) rx_sh <= {rx_sync[1], rx_sh[7:1]};
          if (rx_n == 4'd9) begin
            rx_on <= 1'b0;
            if (rx_sync[1]) begin
              rx_data <= rx_sh;
              rx_valid <= 1'b1;
            end
          end
        end
      end
    end
  end
`else
  logic unused_rx;
  assign unused_rx = uart_rxd;
  assign uart_txd = 1'b1;
  assign tx_busy = 1'b0;
  assign rx_valid = 1'b0;
  assign rx_data = 8'd0;
`endif
endmodule

// File: tb/tb_cpu_pipeline.sv
// tb_cpu_pipeline: directed programs for cpu_pipeline with hand-computed expectations
module tb_cpu_pipeline;
  localparam int CPB = 16;
  logic clk = 1'b0, reset_b = 1'b0, uart_rxd = 1'b1, uart_txd;
  logic [7:0] switch = 8'd0, led;
  logic [6:0] bcd1, bcd2, bcd3, bcd4;
  logic [31:0] prog [$];
  int total = 0, bad = 0;
  cpu_pipeline dut (.clk(clk), .reset_b(reset_b), .switch(switch), .led(led), .bcd1(bcd1),
                    .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4), .uart_rxd(uart_rxd), .uart_txd(uart_txd));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  task automatic boot(input int n);
    reset_b = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'd0;
    foreach (prog[i]) dut.imem[i] = prog[i];
    reset_b = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int t;
    logic [9:0] frame;
    #2 reset_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_led", {24'd0, led}, 32'h00);
    chk("reset_bcd1", {25'd0, bcd1}, 32'h40);
    chk("reset_bcd4", {25'd0, bcd4}, 32'h40);
    chk("reset_txd", {31'd0, uart_txd}, 32'd1);
    chk("reset_pc", dut.pc, 32'd0);
    // lui $7,0x4000; addi $1,$0,5; addi $2,$1,3; sw $2,0($7); j self
    prog = '{32'h3C074000, 32'h20010005, 32'h20220003, 32'hACE20000, 32'h08000004};
    boot(40);
    chk("fwd_led", {24'd0, led}, 32'h08);
    // lui $7; lw $3,4($7); sw $3,0($7); j self
    switch = 8'hA5;
    prog = '{32'h3C074000, 32'h8CE30004, 32'hACE30000, 32'h08000003};
    boot(40);
    chk("load_use_led", {24'd0, led}, 32'hA5);
    // lui $7; ori $6,$0,0x1234; sw $6,8($7); lw $8,8($7); sw $8,0($7); j self
    prog = '{32'h3C074000, 32'h34061234, 32'hACE60008, 32'h8CE80008, 32'hACE80000, 32'h08000005};
    boot(40);
    chk("seg_bcd1", {25'd0, bcd1}, 32'h79);
    chk("seg_bcd2", {25'd0, bcd2}, 32'h24);
    chk("seg_bcd3", {25'd0, bcd3}, 32'h30);
    chk("seg_bcd4", {25'd0, bcd4}, 32'h19);
    chk("seg_readback", {24'd0, led}, 32'h34);
    // lui $7; beq $0,$0,+2; addi $4,$4,1 x2 (skipped); addi $4,$4,7; sw $4,0($7); j self
    prog = '{32'h3C074000, 32'h10000002, 32'h20840001, 32'h20840001, 32'h20840007,
             32'hACE40000, 32'h08000006};
    boot(40);
    chk("branch_skip_led", {24'd0, led}, 32'h07);
    // ALU mix, RAM round trip, jal/jr with flushed wrong-path stores to the display
    prog = '{32'h3C074000, 32'h2001FFFD, 32'h20020006, 32'h00411822, 32'h0022202A, 32'h00032900,
             32'h00A42825, 32'hAC050020, 32'h8C060020, 32'h0C00000C, 32'hACE60000, 32'h0800000B,
             32'h00064102, 32'h001F4A00, 32'h01284825, 32'hACE90008, 32'h03E00008, 32'hACE00008,
             32'hACE00008};
    boot(80);
    chk("alu_ram_led", {24'd0, led}, 32'h91);
    chk("jal_bcd1", {25'd0, bcd1}, 32'h24);
    chk("jal_bcd2", {25'd0, bcd2}, 32'h00);
    chk("jal_bcd3", {25'd0, bcd3}, 32'h40);
    chk("jal_bcd4", {25'd0, bcd4}, 32'h10);
    reset_b = 1'b1;
    #1;
    chk("midreset_led", {24'd0, led}, 32'h00);
    chk("midreset_bcd1", {25'd0, bcd1}, 32'h40);
    chk("midreset_bcd4", {25'd0, bcd4}, 32'h40);
    chk("midreset_pc", dut.pc, 32'd0);
    @(negedge clk);
    reset_b = 1'b0;
    repeat (80) @(negedge clk);
    chk("restart_led", {24'd0, led}, 32'h91);
`ifdef UART_EN
    // lui $7; ori $1,$0,0x55; sw $1,12($7); j self
    prog = '{32'h3C074000, 32'h34010055, 32'hACE1000C, 32'h08000003};
    boot(0);
    t = 0;
    while (uart_txd !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("tx_start_seen", {31'd0, uart_txd}, 32'd0);
    frame = {1'b1, 8'h55, 1'b0};
    repeat (CPB / 2) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("tx_bit%0d", b), {31'd0, uart_txd}, {31'd0, frame[b]});
      chk($sformatf("tx_busy%0d", b), {31'd0, dut.tx_busy}, 32'd1);
      repeat (CPB) @(negedge clk);
    end
    chk("tx_idle", {31'd0, dut.tx_busy}, 32'd0);
    chk("tx_idle_line", {31'd0, uart_txd}, 32'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
